// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: single-cycle CPU vs. host/debug loader with locked bursts and starvation guard.
// Optional DMEM_ARB_STATS_EN adds saturating stall/host-grant counters (tied to 0 otherwise).
module dmem_arbiter #(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic          clk,
  input  logic          rstd,
  input  logic          cpu_req,
  input  logic [3:0]    cpu_we_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_req,
  input  logic          host_lock,
  input  logic [3:0]    host_we_n,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_valid,
  output logic [DW-1:0] host_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wren_n,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   host_cnt
);

  localparam int unsigned WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam int unsigned HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

  typedef enum logic {ARB, HOLD} st_t;

  st_t         st;
  logic [WW-1:0] wait_cnt;
  logic [HW-1:0] hold_cnt;
  logic        wait_max;
  logic        hold_max;
  logic        host_rd;

  assign wait_max = (wait_cnt == WW'(MAX_WAIT));
  assign hold_max = (hold_cnt == HW'(HOLD_MAX));

  // Grant decision; the CPU takes whatever the host does not
  always_comb begin
    host_gnt = 1'b0;
    if (st == ARB) host_gnt = host_req & (~cpu_req | wait_max);
    else           host_gnt = host_req & ~(cpu_req & hold_max);
    cpu_gnt   = cpu_req & ~host_gnt;
    cpu_stall = cpu_req & ~cpu_gnt;
    cpu_rdata = cpu_gnt ? mem_rdata : '0;
  end

  // Memory port mux, idle port parks at address 0 with all lanes disabled
  always_comb begin
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wren_n = 4'b1111;
    if (host_gnt) begin
      mem_addr   = host_addr;
      mem_wdata  = host_wdata;
      mem_wren_n = host_we_n;
    end else if (cpu_gnt) begin
      mem_addr   = cpu_addr;
      mem_wdata  = cpu_wdata;
      mem_wren_n = cpu_we_n;
    end
  end

  assign host_rd = host_gnt & (host_we_n == 4'b1111);

  // Arbitration state, fairness counters and registered host read response
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      st         <= ARB;
      wait_cnt   <= '0;
      hold_cnt   <= '0;
      host_valid <= 1'b0;
      host_rdata <= '0;
    end else begin
      st <= (host_gnt & host_lock) ? HOLD : ARB;

      if (!(host_gnt & host_lock))            hold_cnt <= '0;
      else if ((st == HOLD) && !hold_max)     hold_cnt <= hold_cnt + HW'(1);

      if (host_req & ~host_gnt) begin
        if (!wait_max) wait_cnt <= wait_cnt + WW'(1);
      end else begin
        wait_cnt <= '0;
      end

      host_valid <= host_rd;
      if (host_rd) host_rdata <= mem_rdata;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Saturating activity counters
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      stall_cnt <= '0;
      host_cnt  <= '0;
    end else begin
      if (cpu_stall && (stall_cnt != 16'hffff)) stall_cnt <= stall_cnt + 16'd1;
      if (host_gnt && (host_cnt != 16'hffff))   host_cnt  <= host_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = '0;
  assign host_cnt  = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256-word byte-lane memory.
module tb_dmem_arbiter;

  logic        clk;
  logic        rstd;
  logic        cpu_req;
  logic [3:0]  cpu_we_n;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        host_req;
  logic        host_lock;
  logic [3:0]  host_we_n;
  logic [7:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_gnt;
  logic        host_valid;
  logic [31:0] host_rdata;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wren_n;
  logic [31:0] mem_rdata;
  logic [15:0] stall_cnt;
  logic [15:0] host_cnt;

  logic [31:0] mem [256];
  logic        load;
  int          n_cmp;
  int          n_err;

  dmem_arbiter dut (
    .clk(clk), .rstd(rstd),
    .cpu_req(cpu_req), .cpu_we_n(cpu_we_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_lock(host_lock), .host_we_n(host_we_n),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_valid(host_valid), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren_n(mem_wren_n),
    .mem_rdata(mem_rdata), .stall_cnt(stall_cnt), .host_cnt(host_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: preload pattern A000_00xx, word 5 = 1122_3344
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + i;
      mem[5] <= 32'h1122_3344;
    end else begin
      for (int b = 0; b < 4; b++)
        if (!mem_wren_n[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_cpu(input logic req, input logic [3:0] we_n, input logic [7:0] addr,
                           input logic [31:0] wdata);
    cpu_req = req; cpu_we_n = we_n; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic drive_host(input logic req, input logic lock, input logic [3:0] we_n,
                            input logic [7:0] addr, input logic [31:0] wdata);
    host_req = req; host_lock = lock; host_we_n = we_n; host_addr = addr; host_wdata = wdata;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    load  = 1'b1;
    rstd  = 1'b0;
    drive_cpu(1'b0, 4'hf, 8'h00, 32'h0);
    drive_host(1'b0, 1'b0, 4'hf, 8'h00, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("rst host_valid", 32'(host_valid), 32'd0);
    check("rst host_rdata", host_rdata, 32'd0);
    check("rst cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("rst host_gnt", 32'(host_gnt), 32'd0);
    check("rst mem_wren_n", 32'(mem_wren_n), 32'hf);
    check("rst mem_addr", 32'(mem_addr), 32'd0);
    check("rst stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst host_cnt", 32'(host_cnt), 32'd0);
    load = 1'b0;
    rstd = 1'b1;

    // CPU read, host idle: zero-latency grant
    @(negedge clk);
    drive_cpu(1'b1, 4'hf, 8'h10, 32'h0);
    #1;
    check("cpu rd gnt", 32'(cpu_gnt), 32'd1);
    check("cpu rd stall", 32'(cpu_stall), 32'd0);
    check("cpu rd mem_addr", 32'(mem_addr), 32'h10);
    check("cpu rd wren_n", 32'(mem_wren_n), 32'hf);
    check("cpu rd rdata", cpu_rdata, 32'hA000_0010);

    // Host full-word write, CPU idle
    @(negedge clk);
    drive_cpu(1'b0, 4'hf, 8'h00, 32'h0);
    drive_host(1'b1, 1'b0, 4'h0, 8'h20, 32'hDEAD_BEEF);
    #1;
    check("hwr gnt", 32'(host_gnt), 32'd1);
    check("hwr cpu_rdata idle", cpu_rdata, 32'd0);
    check("hwr wren_n", 32'(mem_wren_n), 32'h0);
    check("hwr mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    check("hwr no valid", 32'(host_valid), 32'd0);
    check("hwr mem word", mem[8'h20], 32'hDEAD_BEEF);

    // Contention without lock: host starves 4 cycles then wins once
    @(negedge clk);
    drive_host(1'b0, 1'b0, 4'hf, 8'h00, 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive_cpu(1'b1, 4'hf, 8'h40, 32'h0);
      drive_host(1'b1, 1'b0, 4'hf, 8'h30, 32'h0);
      #1;
      check($sformatf("starve host_gnt c%0d", k), 32'(host_gnt), 32'(k == 4));
      check($sformatf("starve cpu_gnt c%0d", k), 32'(cpu_gnt), 32'(k != 4));
      check($sformatf("starve stall c%0d", k), 32'(cpu_stall), 32'(k == 4));
      @(posedge clk);
      #1;
      check($sformatf("starve valid c%0d", k), 32'(host_valid), 32'(k == 4));
      if (k == 4) check("starve rdata", host_rdata, 32'hA000_0030);
    end

    // Locked host read burst: entry + 8 HOLD grants, then CPU forced in
    @(negedge clk);
    drive_cpu(1'b0, 4'hf, 8'h00, 32'h0);
    drive_host(1'b0, 1'b0, 4'hf, 8'h00, 32'h0);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive_cpu(i > 0, 4'hf, 8'h44, 32'h0);
      drive_host(1'b1, 1'b1, 4'hf, 8'(8'h50 + i), 32'h0);
      #1;
      check($sformatf("burst host_gnt b%0d", i), 32'(host_gnt), 32'(i <= 8));
      check($sformatf("burst cpu_gnt b%0d", i), 32'(cpu_gnt), 32'(i >= 9));
      @(posedge clk);
      #1;
      check($sformatf("burst valid b%0d", i), 32'(host_valid), 32'(i <= 8));
      if (i <= 8) check($sformatf("burst rdata b%0d", i), host_rdata, 32'hA000_0050 + 32'(i));
    end

    // Byte-lane write then host read-back
    @(negedge clk);
    drive_cpu(1'b0, 4'hf, 8'h00, 32'h0);
    drive_host(1'b0, 1'b0, 4'hf, 8'h00, 32'h0);
    @(negedge clk);
    drive_host(1'b1, 1'b0, 4'b1110, 8'h05, 32'h0000_00AB);
    #1;
    check("lane wr gnt", 32'(host_gnt), 32'd1);
    @(negedge clk);
    drive_host(1'b1, 1'b0, 4'hf, 8'h05, 32'h0);
    @(posedge clk);
    #1;
    check("lane rd valid", 32'(host_valid), 32'd1);
    check("lane rd rdata", host_rdata, 32'h1122_33AB);

    // Reset while locked with a read response pending
    @(negedge clk);
    drive_host(1'b1, 1'b1, 4'hf, 8'h60, 32'h0);
    @(posedge clk);
    #1;
    check("pre-rst valid", 32'(host_valid), 32'd1);
    rstd = 1'b0;
    drive_host(1'b0, 1'b0, 4'hf, 8'h00, 32'h0);
    #1;
    check("mid-rst valid", 32'(host_valid), 32'd0);
    check("mid-rst rdata", host_rdata, 32'd0);
    check("mid-rst host_gnt", 32'(host_gnt), 32'd0);
    check("mid-rst wren_n", 32'(mem_wren_n), 32'hf);
    @(negedge clk);
    rstd = 1'b1;
    drive_cpu(1'b1, 4'hf, 8'h12, 32'h0);
    drive_host(1'b1, 1'b1, 4'hf, 8'h60, 32'h0);
    #1;
    check("post-rst cpu_gnt", 32'(cpu_gnt), 32'd1);
    check("post-rst host_gnt", 32'(host_gnt), 32'd0);
    check("post-rst cpu_rdata", cpu_rdata, 32'hA000_0012);

`ifndef DMEM_ARB_STATS_EN
    check("stall_cnt tied", 32'(stall_cnt), 32'd0);
    check("host_cnt tied", 32'(host_cnt), 32'd0);
`endif

    @(negedge clk);
    drive_cpu(1'b0, 4'hf, 8'h00, 32'h0);
    drive_host(1'b0, 1'b0, 4'hf, 8'h00, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (four 8-bit byte lanes, active-low lane write enables) between the CPU execute stage and a host/debug loader.
- The CPU side is single-cycle, so a granted CPU access completes combinationally in the same cycle. A denied CPU access raises cpu_stall, which freezes the PC/regfile update.
- The host side uses a req/gnt handshake with a registered read response, optional locked bursts, and a starvation guard.

Parameters:
- AW, 8, word address width presented to data memory.
- DW, 32, data width (4 byte lanes).
- MAX_WAIT, 4, consecutive denied host cycles before the host is forced to win.
- HOLD_MAX, 8, maximum consecutive host-locked grants before the CPU must be served.

Ports:
- clk  in  1  clock
- rstd  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU memory access this cycle
- cpu_we_n  in  4  CPU lane write enables, active-low; 4'b1111 = read
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  CPU owns the port this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt; CPU must not advance
- cpu_rdata  out  DW  mem_rdata when cpu_gnt, else 0
- host_req  in  1  host access request
- host_lock  in  1  host requests to keep ownership for the next access
- host_we_n  in  4  host lane write enables, active-low
- host_addr  in  AW  host word address
- host_wdata  in  DW  host write data
- host_gnt  out  1  host owns the port this cycle
- host_valid  out  1  one-cycle pulse, cycle after a host read grant
- host_rdata  out  DW  registered read data
- mem_addr  out  AW  to data memory
- mem_wdata  out  DW  to data memory
- mem_wren_n  out  4  to data memory lanes, active-low
- mem_rdata  in  DW  combinational read data from memory

Behaviour:
- State register st ∈ {ARB, HOLD}; wait_cnt of width clog2(MAX_WAIT+1), saturating; hold_cnt of width clog2(HOLD_MAX+1).
- Reset (rstd=0, async): st=ARB, wait_cnt=0, hold_cnt=0, host_valid=0, host_rdata=0. All other outputs follow the combinational rules below with the reset state (no requests → gnt=0, mem_wren_n=4'b1111).
- Grant, combinational:
  - ARB: host wins if host_req & (~cpu_req | wait_cnt==MAX_WAIT); otherwise the CPU wins if cpu_req.
  - HOLD: host wins if host_req & ~(cpu_req & hold_cnt==HOLD_MAX).
  - At most one grant per cycle.
- Port mux:
  - Granted requester drives mem_addr, mem_wdata and mem_wren_n.
  - No grant: mem_addr=0, mem_wdata=0, mem_wren_n=4'b1111.
  - Writes commit at the posedge ending the granted cycle.
- wait_cnt:
  - +1 (saturating at MAX_WAIT) each cycle with host_req & ~host_gnt.
  - Cleared on host_gnt or ~host_req.
- Transitions:
  - ARB→HOLD on host_gnt & host_lock.
  - HOLD→HOLD on host_gnt & host_lock.
  - HOLD→ARB otherwise, including ~host_req and forced CPU service.
- hold_cnt:
  - +1 (saturating at HOLD_MAX) per host grant while in HOLD.
  - Cleared on entry to ARB.
  - Once forced back, the CPU gets ≥1 cycle.
- Host response:
  - On host_gnt with host_we_n==4'b1111: host_rdata<=mem_rdata and host_valid=1 in the next cycle.
  - Host writes produce no host_valid.
  - host_rdata holds between reads.
- CPU latency 0 cycles; host read latency 1 cycle; host write commits in the grant cycle.
- Simultaneous cpu_req & host_req with wait_cnt<MAX_WAIT in ARB → CPU granted, host waits.
- Host deasserting host_req mid-HOLD → ARB next cycle, no grant to the host.
- Reset asserted mid-access: outputs return to the reset state immediately. A write in progress is not guaranteed to commit.

Optional Feature:
- DMEM_ARB_STATS_EN adds outputs stall_cnt[15:0] and host_cnt[15:0]:
  - stall_cnt counts cycles with cpu_stall=1; host_cnt counts host grants.
  - Both saturate at 16'hffff and reset to 0 on rstd.
- Without the macro, both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Reset, cpu_req=1 read addr 0x10, host idle → cpu_gnt=1, cpu_stall=0, mem_addr=0x10, mem_wren_n=1111, cpu_rdata=mem_rdata same cycle.
- CPU idle, host write addr 0x20 data 0xDEADBEEF we_n=0000 → host_gnt=1, memory word 0x20 = 0xDEADBEEF; host_valid stays 0.
- cpu_req and host_req held high continuously, no lock → host denied 4 cycles, granted in the 5th (cpu_stall=1 that cycle), wait_cnt back to 0, then CPU granted again.
- Host locked burst of 12 reads with cpu_req=1 and MAX_WAIT=0 to start the burst:
  - host granted 9 consecutive cycles (entry + HOLD_MAX), then the CPU gets 1 cycle;
  - host_valid pulses 1 cycle after each host read with the correct data.
- Host write 0x000000AB with we_n=1110 to addr 5 (previously 0x11223344) → read back 0x112233AB via a host read: host_valid=1 next cycle, host_rdata=0x112233AB.
- Assert rstd=0 during HOLD with host_valid pending → host_valid=0, host_rdata=0 immediately; after release, st=ARB and the first CPU request is granted.
